// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard unit for a five-stage pipeline.
// Optional WB hold path enabled by defining FWD_WB_HOLD_EN.
module fwd_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NPORTS = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NPORTS*ADDR_W-1:0] id_rs,
  input  logic [NPORTS-1:0]        id_rs_used,
  input  logic [ADDR_W-1:0]        id_rd,
  input  logic                     id_we,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic [NPORTS*DATA_W-1:0] ex_reg_value,
  input  logic [DATA_W-1:0]        mem_result,
  input  logic [DATA_W-1:0]        wb_result,
  output logic                     stall,
  output logic [NPORTS*2-1:0]      ex_fwd_sel,
  output logic [NPORTS*DATA_W-1:0] ex_operand,
  output logic [CNT_W-1:0]         stall_count
);

  logic              r_ex_v, r_ex_ld, r_mem_v;
  logic [ADDR_W-1:0] r_ex_rd, r_mem_rd;
`ifdef FWD_WB_HOLD_EN
  logic              r_wb_v;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_hold;
`endif
  logic [NPORTS*2-1:0] r_sel;
  logic [CNT_W-1:0]    r_cnt;

  logic [NPORTS*2-1:0] w_sel;
  logic                w_load_hit;
  logic                w_adv;
  logic [ADDR_W-1:0]   w_rs;
  logic                w_chk;

  // Newest producer wins: EX over MEM over WB.
  always_comb begin
    w_sel      = '0;
    w_load_hit = 1'b0;
    w_rs       = '0;
    w_chk      = 1'b0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      w_rs  = id_rs[p*ADDR_W +: ADDR_W];
      w_chk = id_rs_used[p] && (w_rs != '0);
      if (w_chk && r_ex_v && (r_ex_rd == w_rs)) begin
        w_sel[p*2 +: 2] = 2'b10;
        if (r_ex_ld) w_load_hit = 1'b1;
      end else if (w_chk && r_mem_v && (r_mem_rd == w_rs)) begin
        w_sel[p*2 +: 2] = 2'b01;
`ifdef FWD_WB_HOLD_EN
      end else if (w_chk && r_wb_v && (r_wb_rd == w_rs)) begin
        w_sel[p*2 +: 2] = 2'b11;
`endif
      end
    end
  end

  assign stall = ~flush & id_valid & w_load_hit;
  assign w_adv = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_v   <= 1'b0;
      r_ex_rd  <= '0;
      r_ex_ld  <= 1'b0;
      r_mem_v  <= 1'b0;
      r_mem_rd <= '0;
`ifdef FWD_WB_HOLD_EN
      r_wb_v   <= 1'b0;
      r_wb_rd  <= '0;
      r_hold   <= '0;
`endif
      r_sel    <= '0;
      r_cnt    <= '0;
    end else begin
      r_ex_v   <= w_adv & id_we & (id_rd != '0);
      r_ex_rd  <= id_rd;
      r_ex_ld  <= id_is_load;
      r_mem_v  <= r_ex_v;
      r_mem_rd <= r_ex_rd;
`ifdef FWD_WB_HOLD_EN
      r_wb_v   <= r_mem_v;
      r_wb_rd  <= r_mem_rd;
      r_hold   <= wb_result;
`endif
      r_sel    <= w_adv ? w_sel : '0;
      if (stall && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ex_operand = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      case (r_sel[p*2 +: 2])
        2'b10:   ex_operand[p*DATA_W +: DATA_W] = mem_result;
        2'b01:   ex_operand[p*DATA_W +: DATA_W] = wb_result;
`ifdef FWD_WB_HOLD_EN
        2'b11:   ex_operand[p*DATA_W +: DATA_W] = r_hold;
`endif
        default: ex_operand[p*DATA_W +: DATA_W] = ex_reg_value[p*DATA_W +: DATA_W];
      endcase
    end
  end

  assign ex_fwd_sel  = r_sel;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed cases plus random traffic vs a history model.
module tb_fwd_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;
`ifdef FWD_WB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid, id_we, id_is_load, flush;
  logic [NP*AW-1:0] id_rs;
  logic [NP-1:0]    id_rs_used;
  logic [AW-1:0]    id_rd;
  logic [NP*DW-1:0] ex_reg_value;
  logic [DW-1:0]    mem_result, wb_result;
  logic             stall, stall_b;
  logic [NP*2-1:0]  sel, sel_b;
  logic [NP*DW-1:0] op, op_b;
  logic [15:0]      cnt;
  logic [1:0]       cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
    .ex_reg_value(ex_reg_value), .mem_result(mem_result), .wb_result(wb_result),
    .stall(stall), .ex_fwd_sel(sel), .ex_operand(op), .stall_count(cnt)
  );

  fwd_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
    .ex_reg_value(ex_reg_value), .mem_result(mem_result), .wb_result(wb_result),
    .stall(stall_b), .ex_fwd_sel(sel_b), .ex_operand(op_b), .stall_count(cnt_b)
  );

  // Model: history of the last three instructions issued into EX, index = age.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          ld;
  } tag_t;

  tag_t        m_pipe [3];
  logic [1:0]  m_sel  [NP];
  logic [DW-1:0] m_hold;
  int          m_cnt;

  function automatic bit m_hit(int p, int age);
    logic [AW-1:0] rs;
    rs = id_rs[p*AW +: AW];
    return id_rs_used[p] && (rs != 0) && m_pipe[age].v && (m_pipe[age].rd == rs);
  endfunction

  function automatic logic [1:0] m_pick(int p);
    if (m_hit(p, 0)) return 2'b10;
    if (m_hit(p, 1)) return 2'b01;
    if (m_hit(p, 2)) return HOLD ? 2'b11 : 2'b00;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    if (flush || !id_valid) return 1'b0;
    for (int p = 0; p < NP; p++)
      if (m_hit(p, 0) && m_pipe[0].ld) s = 1'b1;
    return s;
  endfunction

  function automatic logic [DW-1:0] m_op(int p);
    case (m_sel[p])
      2'b10:   return mem_result;
      2'b01:   return wb_result;
      2'b11:   return HOLD ? m_hold : ex_reg_value[p*DW +: DW];
      default: return ex_reg_value[p*DW +: DW];
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < 3; a++) m_pipe[a] <= '0;
      for (int p = 0; p < NP; p++) m_sel[p] <= 2'b00;
      m_hold <= '0;
      m_cnt  <= 0;
    end else begin
      bit stl, adv;
      stl = m_stall();
      adv = id_valid && !stl && !flush;
      for (int p = 0; p < NP; p++) m_sel[p] <= adv ? m_pick(p) : 2'b00;
      if (stl) m_cnt <= m_cnt + 1;
      m_hold    <= wb_result;
      m_pipe[2] <= m_pipe[1];
      m_pipe[1] <= m_pipe[0];
      m_pipe[0] <= '{v: adv && id_we && (id_rd != 0), rd: id_rd, ld: id_is_load};
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit es;
    es = m_stall();
    chk("stall", 64'(stall), 64'(es));
    chk("stall_sat", 64'(stall_b), 64'(es));
    for (int p = 0; p < NP; p++) begin
      chk("fwd_sel", 64'(sel[p*2 +: 2]), 64'(m_sel[p]));
      chk("operand", 64'(op[p*DW +: DW]), 64'(m_op(p)));
    end
    chk("stall_count", 64'(cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("stall_count_sat", 64'(cnt_b), 64'((m_cnt > 3) ? 3 : m_cnt));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_we = 0; id_is_load = 0; flush = 0;
  endtask

  task automatic instr(logic [AW-1:0] rs0, logic u0, logic [AW-1:0] rd, logic we, logic ld);
    id_valid = 1; id_rs = {{AW{1'b0}}, rs0}; id_rs_used = {1'b0, u0};
    id_rd = rd; id_we = we; id_is_load = ld; flush = 0;
  endtask

  task automatic rst();
    reset = 1; idle(); cyc(); reset = 0; #1;
  endtask

  initial begin
    idle();
    ex_reg_value = {32'h2222_2222, 32'h1111_1111};
    mem_result = 32'h0BAD_0001;
    wb_result  = 32'h0BAD_0002;
    reset = 1;
    cyc(); cyc();
    reset = 0;
    cyc();
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_count", 64'(cnt), 64'd0);
    chk("reset_sel", 64'(sel), 64'd0);
    chk("reset_operand", 64'(op[31:0]), 64'h1111_1111);

    // EX -> MEM forward
    instr(5'd0, 1'b0, 5'd5, 1'b1, 1'b0); cyc();
    instr(5'd5, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
    idle(); mem_result = 32'hDEAD_BEEF; #1;
    chk("exmem_sel", 64'(sel[1:0]), 64'b10);
    chk("exmem_operand", 64'(op[31:0]), 64'hDEAD_BEEF);

    // Newest producer has priority
    instr(5'd0, 1'b0, 5'd7, 1'b1, 1'b0); cyc();
    instr(5'd0, 1'b0, 5'd7, 1'b1, 1'b0); cyc();
    instr(5'd7, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
    idle(); #1;
    chk("priority_sel", 64'(sel[1:0]), 64'b10);

    // x0 never forwarded
    instr(5'd0, 1'b0, 5'd0, 1'b1, 1'b0); cyc();
    instr(5'd0, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
    idle(); #1;
    chk("x0_sel", 64'(sel[1:0]), 64'b00);

    // Load-use: one stall, then WB forward
    rst();
    instr(5'd0, 1'b0, 5'd3, 1'b1, 1'b1); cyc();
    instr(5'd3, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("lu_stall", 64'(stall), 64'd1);
    cyc();
    chk("lu_stall_drop", 64'(stall), 64'd0);
    chk("lu_count", 64'(cnt), 64'd1);
    cyc();
    idle(); wb_result = 32'h0000_00A5; #1;
    chk("lu_sel", 64'(sel[1:0]), 64'b01);
    chk("lu_operand", 64'(op[31:0]), 64'h0000_00A5);

    // Flush beats stall
    instr(5'd0, 1'b0, 5'd3, 1'b1, 1'b1); cyc();
    instr(5'd3, 1'b1, 5'd0, 1'b0, 1'b0); flush = 1; #1;
    chk("flush_stall", 64'(stall), 64'd0);
    cyc();
    idle(); #1;
    chk("flush_count", 64'(cnt), 64'd1);
    chk("flush_sel", 64'(sel[1:0]), 64'b00);

    // Back-to-back loads: hazard re-evaluated right after a stall
    rst();
    instr(5'd0, 1'b0, 5'd3, 1'b1, 1'b1); cyc();
    instr(5'd3, 1'b1, 5'd6, 1'b1, 1'b1); #1;
    chk("b2b_stall1", 64'(stall), 64'd1);
    cyc(); cyc();
    instr(5'd6, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("b2b_stall2", 64'(stall), 64'd1);
    cyc(); cyc(); idle(); #1;
    chk("b2b_count", 64'(cnt), 64'd2);

    // Saturation on the 2-bit counter
    rst();
    repeat (5) begin
      instr(5'd0, 1'b0, 5'd3, 1'b1, 1'b1); cyc();
      instr(5'd3, 1'b1, 5'd0, 1'b0, 1'b0); cyc(); cyc();
    end
    idle(); #1;
    chk("sat_count2", 64'(cnt_b), 64'd3);
    chk("sat_count16", 64'(cnt), 64'd5);

    // Reader three cycles after its writer
    rst();
    instr(5'd0, 1'b0, 5'd9, 1'b1, 1'b0); cyc();
    idle(); cyc(); cyc();
    instr(5'd9, 1'b1, 5'd0, 1'b0, 1'b0); wb_result = 32'hCAFE_0009; cyc();
    idle(); wb_result = 32'h1234_5678; ex_reg_value = {32'h2222_2222, 32'h5555_5555}; #1;
    if (HOLD) begin
      chk("hold_sel", 64'(sel[1:0]), 64'b11);
      chk("hold_operand", 64'(op[31:0]), 64'hCAFE_0009);
    end else begin
      chk("wb_sel", 64'(sel[1:0]), 64'b00);
      chk("wb_operand", 64'(op[31:0]), 64'h5555_5555);
    end

    // Random traffic on a small register window to provoke hits
    for (int i = 0; i < 3000; i++) begin
      id_valid     = ($urandom % 4) != 0;
      id_rs        = {AW'($urandom % 4), AW'($urandom % 4)};
      id_rs_used   = NP'($urandom);
      id_rd        = AW'($urandom % 4);
      id_we        = ($urandom % 4) != 0;
      id_is_load   = ($urandom % 3) == 0;
      flush        = ($urandom % 10) == 0;
      ex_reg_value = {$urandom, $urandom};
      mem_result   = $urandom;
      wb_result    = $urandom;
      reset        = ($urandom % 200) == 0;
      cyc();
    end
    reset = 0;
    idle();
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the five-stage pipeline. The block tracks destination tags of in-flight instructions in EX, MEM and WB, and computes one forward select per read port when an instruction leaves ID. It registers each select into EX and drives the EX operand muxes from the register file, MEM and WB sources. It also detects load-use hazards, raises a one-cycle stall with bubble insertion, and keeps a saturating stall counter.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width; address 0 is hard-wired zero
- NPORTS, 2, number of source-operand read ports
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- id_valid  input  1  valid instruction in ID
- id_rs  input  NPORTS*ADDR_W  source addresses; port p at [p*ADDR_W +: ADDR_W]
- id_rs_used  input  NPORTS  port p actually reads id_rs[p]
- id_rd  input  ADDR_W  destination address
- id_we  input  1  instruction writes the register file
- id_is_load  input  1  instruction is a load
- flush  input  1  kill the ID instruction; a bubble enters EX
- ex_reg_value  input  NPORTS*DATA_W  register-file values carried in the ID/EX register
- mem_result  input  DATA_W  ALU result in MEM
- wb_result  input  DATA_W  final write-back value in WB
- stall  output  1  hold IF/ID this cycle
- ex_fwd_sel  output  NPORTS*2  registered select per port
- ex_operand  output  NPORTS*DATA_W  forwarded EX operands
- stall_count  output  CNT_W  saturating count of stall cycles

## Operation
- Tag format: {valid, rd, is_load}. There are three tag registers: ex_tag, mem_tag, wb_tag.
- The tags shift every clock: ex_tag→mem_tag→wb_tag. The stages from EX onward never stall.
- New ex_tag:
  - valid = id_valid & ~stall & ~flush & id_we & (id_rd != 0)
  - otherwise the new ex_tag is a bubble with valid = 0.
- Hit rule: port p hits tag T when all of these hold: id_rs_used[p], id_rs[p] != 0, T.valid, T.rd == id_rs[p].
- Select for port p, computed at ID; the newest source wins:
  - 10 (MEM) if p hits ex_tag
  - else 01 (WB) if p hits mem_tag
  - else 11 (HOLD) if p hits wb_tag and FWD_WB_HOLD_EN is defined
  - else 00 (REG)
- ex_fwd_sel[p] loads the computed select when a valid, unstalled, unflushed instruction advances. Otherwise it loads 00.
- ex_operand[p] is selected by ex_fwd_sel[p]:
  - 00 → ex_reg_value[p]
  - 10 → mem_result
  - 01 → wb_result
  - 11 → hold_reg
- Load-use stall:
  - stall = ~flush & id_valid & (some port hits ex_tag & ex_tag.is_load).
  - While stalled, a bubble enters EX. On the next cycle the load sits in mem_tag, so the select recomputes to 01 and stall drops.
- flush has priority over stall: flush forces stall = 0 and a bubble.
- stall_count increments by 1 on every cycle with stall = 1 and saturates at 2^CNT_W − 1.

## Timing
- Reset values: all tags invalid, ex_fwd_sel = 0, hold_reg = 0, stall_count = 0.
  - As a result, stall = 0 and ex_operand = ex_reg_value.
- stall and the computed select are combinational from the ID inputs and the current tags, within the same cycle.
- ex_fwd_sel has 1-cycle latency from ID. ex_operand is combinational from ex_fwd_sel and the data inputs.
- Load-use hazard costs exactly 1 stall cycle per offending load.
- A new hazard on the cycle right after a stall (back-to-back loads) is evaluated fresh.
- Reset asserted mid-operation clears all tags and selects at once. In-flight forwarding is abandoned.

## Configuration
- FWD_WB_HOLD_EN defined:
  - adds a DATA_W hold_reg that captures wb_result on every clock
  - select 11 forwards the value the register file missed when it is not write-through.
- FWD_WB_HOLD_EN undefined:
  - no hold_reg; a wb_tag hit yields select 00, relying on a write-through register file
  - select 11 never occurs; if forced, ex_operand = ex_reg_value.

## Test plan
- Reset:
  - stimulus: reset high, then low; id_valid = 0
  - required: stall = 0, stall_count = 0, ex_fwd_sel = 0, ex_operand = ex_reg_value (0x1111_1111 passes through).
- EX→MEM forward:
  - stimulus: ALU write to x5, then next cycle a reader of x5 on port 0
  - required: ex_fwd_sel[0] = 10; ex_operand[0] = mem_result (0xDEAD_BEEF).
- Priority:
  - stimulus: writes to x7 in two consecutive cycles, then a reader of x7
  - required: select 10, not 01.
- x0 never forwarded:
  - stimulus: write to x0 followed by a reader of x0
  - required: select 00.
- Load-use:
  - stimulus: load to x3, then a reader of x3
  - required: stall = 1 for exactly 1 cycle, stall_count = 1; the reader then gets select 01 with ex_operand = wb_result (0x0000_00A5).
  - repeat the same stimulus with flush = 1 on the hazard cycle: required stall = 0 and stall_count unchanged.
- Saturation and HOLD:
  - stimulus: CNT_W = 2, 5 load-use stalls
  - required: stall_count stops at 3.
  - with FWD_WB_HOLD_EN defined, a reader 3 cycles after its writer gets select 11, and ex_operand equals the earlier wb_result.
